// File: rtl/slot_pkg.sv
// Shared definitions for the DMA slot descriptor table: field codes,
// slot status codes and sequencer states.
package slot_pkg;

  localparam int NUM_FIELDS = 6;

  typedef enum logic [2:0] {
    F_SRC_ADDR = 3'd0,
    F_SRC_SIZE = 3'd1,
    F_DES_ADDR = 3'd2,
    F_DES_SIZE = 3'd3,
    F_STATUS   = 3'd4,
    F_PROFILE  = 3'd5
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RUNNING = 2'd2,
    ST_DONE    = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } seq_state_e;

  function automatic logic field_valid(input logic [2:0] f);
    return f <= 3'd5;
  endfunction

endpackage

// File: rtl/slot_table_if.sv
// Host register port plus sequencer issue port of the slot table.
interface slot_table_if #(
  parameter int IDX_WIDTH      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int SRC_SIZE_WIDTH = 26,
  parameter int DST_ADDR_WIDTH = 32,
  parameter int DST_SIZE_WIDTH = 26
) ();

  logic                      wr_en;
  logic [IDX_WIDTH-1:0]      wr_idx;
  logic [2:0]                wr_field;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [IDX_WIDTH-1:0]      rd_idx;
  logic [2:0]                rd_field;
  logic [DATA_WIDTH-1:0]     rd_data;

  logic                      seq_start;
  logic [IDX_WIDTH:0]        seq_count;
  logic                      seq_abort;
  logic                      seq_busy;
  logic                      seq_done;
  logic                      seq_err;

  logic                      cur_valid;
  logic                      cur_ack;
  logic [IDX_WIDTH-1:0]      cur_idx;
  logic [SRC_ADDR_WIDTH-1:0] cur_src_addr;
  logic [SRC_SIZE_WIDTH-1:0] cur_src_size;
  logic [DST_ADDR_WIDTH-1:0] cur_des_addr;
  logic [DST_SIZE_WIDTH-1:0] cur_des_size;

  modport master (
    output wr_en, wr_idx, wr_field, wr_data, rd_idx, rd_field,
    output seq_start, seq_count, seq_abort, cur_ack,
    input  rd_data, seq_busy, seq_done, seq_err,
    input  cur_valid, cur_idx, cur_src_addr, cur_src_size, cur_des_addr, cur_des_size
  );

  modport slave (
    input  wr_en, wr_idx, wr_field, wr_data, rd_idx, rd_field,
    input  seq_start, seq_count, seq_abort, cur_ack,
    output rd_data, seq_busy, seq_done, seq_err,
    output cur_valid, cur_idx, cur_src_addr, cur_src_size, cur_des_addr, cur_des_size
  );

endinterface

// File: rtl/slot_entry.sv
// One DMA slot descriptor: host-writable fields plus hardware status
// override and a saturating cycle profile counter.
module slot_entry
  import slot_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int SRC_SIZE_WIDTH = 26,
  parameter int DST_ADDR_WIDTH = 32,
  parameter int DST_SIZE_WIDTH = 26,
  parameter int STATUS_WIDTH   = 2,
  parameter int PROFILE_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_FIELDS-1:0]     i_we,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic                      i_stat_we,
  input  logic [STATUS_WIDTH-1:0]   i_stat_val,
  input  logic                      i_prof_clr,
  input  logic                      i_prof_inc,
  output logic [SRC_ADDR_WIDTH-1:0] o_src_addr,
  output logic [SRC_SIZE_WIDTH-1:0] o_src_size,
  output logic [DST_ADDR_WIDTH-1:0] o_des_addr,
  output logic [DST_SIZE_WIDTH-1:0] o_des_size,
  output logic [STATUS_WIDTH-1:0]   o_status,
  output logic [PROFILE_WIDTH-1:0]  o_profile
);

  logic [SRC_ADDR_WIDTH-1:0] r_src_addr;
  logic [SRC_SIZE_WIDTH-1:0] r_src_size;
  logic [DST_ADDR_WIDTH-1:0] r_des_addr;
  logic [DST_SIZE_WIDTH-1:0] r_des_size;
  logic [STATUS_WIDTH-1:0]   r_status;
  logic [PROFILE_WIDTH-1:0]  r_profile;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src_addr <= '0;
      r_src_size <= '0;
      r_des_addr <= '0;
      r_des_size <= '0;
      r_status   <= '0;
      r_profile  <= '0;
    end else begin
      if (i_we[F_SRC_ADDR]) r_src_addr <= i_wdata[SRC_ADDR_WIDTH-1:0];
      if (i_we[F_SRC_SIZE]) r_src_size <= i_wdata[SRC_SIZE_WIDTH-1:0];
      if (i_we[F_DES_ADDR]) r_des_addr <= i_wdata[DST_ADDR_WIDTH-1:0];
      if (i_we[F_DES_SIZE]) r_des_size <= i_wdata[DST_SIZE_WIDTH-1:0];
      // Sequencer status updates win over a host write in the same cycle
      if (i_stat_we)
        r_status <= i_stat_val;
      else if (i_we[F_STATUS])
        r_status <= i_wdata[STATUS_WIDTH-1:0];
      if (i_prof_clr)
        r_profile <= '0;
      else if (i_we[F_PROFILE])
        r_profile <= i_wdata[PROFILE_WIDTH-1:0];
      else if (i_prof_inc && (r_profile != '1))
        r_profile <= r_profile + PROFILE_WIDTH'(1);
    end
  end

  assign o_src_addr = r_src_addr;
  assign o_src_size = r_src_size;
  assign o_des_addr = r_des_addr;
  assign o_des_size = r_des_size;
  assign o_status   = r_status;
  assign o_profile  = r_profile;

endmodule

// File: rtl/slot_table.sv
// Bank of DMA slot descriptors with indexed host access and a sequencer that
// issues slots 0..seq_count-1 in order to the downstream engine.
module slot_table
  import slot_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int IDX_WIDTH      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int SRC_SIZE_WIDTH = 26,
  parameter int DST_ADDR_WIDTH = 32,
  parameter int DST_SIZE_WIDTH = 26,
  parameter int STATUS_WIDTH   = 2,
  parameter int PROFILE_WIDTH  = 32
) (
  input logic         clk,
  input logic         reset,
  slot_table_if.slave bus
);

  localparam logic [IDX_WIDTH:0] LP_NUM_SLOTS = (IDX_WIDTH+1)'(NUM_SLOTS);

  seq_state_e                r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0]      r_cur_idx, w_cur_idx_nxt, w_cur_idx_inc;
  logic [IDX_WIDTH:0]        r_seq_count, w_seq_count_nxt;
  logic                      r_seq_err, w_seq_err_nxt;
  logic [DATA_WIDTH-1:0]     r_rd_data, w_rd_mux;

  logic                      w_start, w_ack, w_abort, w_advance;
  logic                      w_last, w_count_ok, w_host_ok;
  logic [NUM_SLOTS-1:0]      w_cur_sel, w_next_sel;
  logic [NUM_SLOTS-1:0]      w_stat_we, w_prof_clr, w_prof_inc;
  logic [STATUS_WIDTH-1:0]   w_stat_val [NUM_SLOTS];
  logic [NUM_FIELDS-1:0]     w_field_we [NUM_SLOTS];

  logic [SRC_ADDR_WIDTH-1:0] w_src_addr [NUM_SLOTS];
  logic [SRC_SIZE_WIDTH-1:0] w_src_size [NUM_SLOTS];
  logic [DST_ADDR_WIDTH-1:0] w_des_addr [NUM_SLOTS];
  logic [DST_SIZE_WIDTH-1:0] w_des_size [NUM_SLOTS];
  logic [STATUS_WIDTH-1:0]   w_status   [NUM_SLOTS];
  logic [PROFILE_WIDTH-1:0]  w_profile  [NUM_SLOTS];

  assign w_cur_idx_inc = r_cur_idx + IDX_WIDTH'(1);
  assign w_last        = ({1'b0, r_cur_idx} + (IDX_WIDTH+1)'(1)) == r_seq_count;
  assign w_count_ok    = (bus.seq_count != '0) && (bus.seq_count <= LP_NUM_SLOTS);

  // The slot being issued is locked against host writes
  assign w_host_ok = bus.wr_en
                  && ({1'b0, bus.wr_idx} < LP_NUM_SLOTS)
                  && field_valid(bus.wr_field)
                  && !((r_state == S_RUN) && (bus.wr_idx == r_cur_idx));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cur_idx   <= '0;
      r_seq_count <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_idx   <= w_cur_idx_nxt;
      r_seq_count <= w_seq_count_nxt;
      r_seq_err   <= w_seq_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_idx_nxt   = r_cur_idx;
    w_seq_count_nxt = r_seq_count;
    w_seq_err_nxt   = 1'b0;
    w_start         = 1'b0;
    w_ack           = 1'b0;
    w_abort         = 1'b0;
    w_advance       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.seq_start) begin
          if (w_count_ok) begin
            w_state_nxt     = S_RUN;
            w_cur_idx_nxt   = '0;
            w_seq_count_nxt = bus.seq_count;
            w_start         = 1'b1;
          end else begin
            w_seq_err_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Abort outranks an acknowledge arriving in the same cycle
        if (bus.seq_abort) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (bus.cur_ack) begin
          w_ack = 1'b1;
          if (w_last) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_cur_idx_nxt = w_cur_idx_inc;
            w_advance     = 1'b1;
          end
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_cur_sel[i]  = (r_cur_idx == IDX_WIDTH'(i));
      w_next_sel[i] = (w_cur_idx_inc == IDX_WIDTH'(i));
    end
  end

  always_comb begin
    w_stat_we  = '0;
    w_prof_clr = '0;
    w_prof_inc = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_stat_val[i] = STATUS_WIDTH'(ST_IDLE);
      w_field_we[i] = '0;
      if (w_start && (i == 0)) begin
        w_stat_we[i]  = 1'b1;
        w_stat_val[i] = STATUS_WIDTH'(ST_RUNNING);
        w_prof_clr[i] = 1'b1;
      end
      if ((r_state == S_RUN) && w_cur_sel[i]) begin
        w_prof_inc[i] = 1'b1;
        if (w_abort) begin
          w_stat_we[i]  = 1'b1;
          w_stat_val[i] = STATUS_WIDTH'(ST_IDLE);
        end else if (w_ack) begin
          w_stat_we[i]  = 1'b1;
          w_stat_val[i] = STATUS_WIDTH'(ST_DONE);
        end
      end
      if (w_advance && w_next_sel[i]) begin
        w_stat_we[i]  = 1'b1;
        w_stat_val[i] = STATUS_WIDTH'(ST_RUNNING);
        w_prof_clr[i] = 1'b1;
      end
      if (w_host_ok && (bus.wr_idx == IDX_WIDTH'(i)))
        w_field_we[i] = NUM_FIELDS'(1) << bus.wr_field;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    slot_entry #(
      .DATA_WIDTH     (DATA_WIDTH),
      .SRC_ADDR_WIDTH (SRC_ADDR_WIDTH),
      .SRC_SIZE_WIDTH (SRC_SIZE_WIDTH),
      .DST_ADDR_WIDTH (DST_ADDR_WIDTH),
      .DST_SIZE_WIDTH (DST_SIZE_WIDTH),
      .STATUS_WIDTH   (STATUS_WIDTH),
      .PROFILE_WIDTH  (PROFILE_WIDTH)
    ) u_entry (
      .clk        (clk),
      .reset      (reset),
      .i_we       (w_field_we[g]),
      .i_wdata    (bus.wr_data),
      .i_stat_we  (w_stat_we[g]),
      .i_stat_val (w_stat_val[g]),
      .i_prof_clr (w_prof_clr[g]),
      .i_prof_inc (w_prof_inc[g]),
      .o_src_addr (w_src_addr[g]),
      .o_src_size (w_src_size[g]),
      .o_des_addr (w_des_addr[g]),
      .o_des_size (w_des_size[g]),
      .o_status   (w_status[g]),
      .o_profile  (w_profile[g])
    );
  end

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bus.rd_idx == IDX_WIDTH'(i)) begin
        case (bus.rd_field)
          F_SRC_ADDR: w_rd_mux = DATA_WIDTH'(w_src_addr[i]);
          F_SRC_SIZE: w_rd_mux = DATA_WIDTH'(w_src_size[i]);
          F_DES_ADDR: w_rd_mux = DATA_WIDTH'(w_des_addr[i]);
          F_DES_SIZE: w_rd_mux = DATA_WIDTH'(w_des_size[i]);
          F_STATUS:   w_rd_mux = DATA_WIDTH'(w_status[i]);
          F_PROFILE:  w_rd_mux = DATA_WIDTH'(w_profile[i]);
          default:    w_rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rd_data <= '0;
    else        r_rd_data <= w_rd_mux;
  end

  always_comb begin
    bus.cur_src_addr = '0;
    bus.cur_src_size = '0;
    bus.cur_des_addr = '0;
    bus.cur_des_size = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_cur_sel[i]) begin
        bus.cur_src_addr = w_src_addr[i];
        bus.cur_src_size = w_src_size[i];
        bus.cur_des_addr = w_des_addr[i];
        bus.cur_des_size = w_des_size[i];
      end
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.cur_idx   = r_cur_idx;
  assign bus.cur_valid = (r_state == S_RUN);
  assign bus.seq_busy  = (r_state != S_IDLE);
  assign bus.seq_done  = (r_state == S_FINISH);
  assign bus.seq_err   = r_seq_err;

endmodule

// File: tb/tb_slot_table.sv
// Scoreboard bench for slot_table: directed host and sequencer traffic,
// with expected reads, issues and pulses checked by a negedge monitor.
module tb_slot_table;
  import slot_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slot_table_if #(.IDX_WIDTH(2), .DATA_WIDTH(32), .SRC_ADDR_WIDTH(32),
                  .SRC_SIZE_WIDTH(26), .DST_ADDR_WIDTH(32), .DST_SIZE_WIDTH(26)) bus ();

  slot_table #(.NUM_SLOTS(4), .IDX_WIDTH(2), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] src;
    logic [31:0] des;
  } issue_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic        rd_strobe = 1'b0;
  logic        rd_pend   = 1'b0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  issue_t      iss_q[$];
  int          done_q[$];
  int          err_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected at cycle %0d", name, cyc);
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues
  initial begin
    issue_t      it;
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (rd_exp_q.size() > 0) begin
          e = rd_exp_q.pop_front();
          n = rd_name_q.pop_front();
          check(n, bus.rd_data, e);
        end else unexpected("rd_extra");
      end
      rd_pend = rd_strobe;
      if (bus.cur_valid && bus.cur_ack) begin
        if (iss_q.size() > 0) begin
          it = iss_q.pop_front();
          check("issue_idx", {30'b0, bus.cur_idx}, {30'b0, it.idx});
          check("issue_src", bus.cur_src_addr, it.src);
          check("issue_des", bus.cur_des_addr, it.des);
        end else unexpected("issue_extra");
      end
      if (bus.seq_done) begin
        if (done_q.size() > 0) check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        else unexpected("done_extra");
      end
      if (bus.seq_err) begin
        if (err_q.size() > 0) check("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
        else unexpected("err_extra");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [2:0] f, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_field = f; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, input logic [2:0] f, input logic [31:0] e, input string tag);
    bus.rd_idx = idx; bus.rd_field = f; rd_strobe = 1'b1;
    rd_exp_q.push_back(e);
    rd_name_q.push_back($sformatf("%s s%0d f%0d", tag, idx, f));
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic push_issue(input int i, input logic [31:0] src, input logic [31:0] des);
    issue_t it;
    it.idx = 2'(i); it.src = src; it.des = des;
    iss_q.push_back(it);
  endtask

  initial begin
    reset = 1'b0;
    bus.wr_en = 0; bus.wr_idx = 0; bus.wr_field = 0; bus.wr_data = 0;
    bus.rd_idx = 0; bus.rd_field = 0;
    bus.seq_start = 0; bus.seq_count = 0; bus.seq_abort = 0; bus.cur_ack = 0;
    tick(3);
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_busy", {31'b0, bus.seq_busy}, 32'h0);
    check("rst_cur_valid", {31'b0, bus.cur_valid}, 32'h0);
    check("rst_cur_idx", {30'b0, bus.cur_idx}, 32'h0);
    reset = 1'b1;
    tick();

    for (int s = 0; s < 4; s++)
      for (int f = 0; f < 6; f++) rd(2'(s), 3'(f), 32'h0, "reset");

    // Write/readback, read-during-write and width truncation
    wr(2'd2, F_SRC_ADDR, 32'hDEAD_BEEF);
    rd(2'd2, F_SRC_ADDR, 32'hDEAD_BEEF, "wr_rd");
    bus.wr_en = 1'b1; bus.wr_idx = 2'd2; bus.wr_field = F_SRC_ADDR; bus.wr_data = 32'h1234_5678;
    bus.rd_idx = 2'd2; bus.rd_field = F_SRC_ADDR; rd_strobe = 1'b1;
    rd_exp_q.push_back(32'hDEAD_BEEF); rd_name_q.push_back("rdw_old");
    tick();
    bus.wr_en = 1'b0; rd_strobe = 1'b0;
    rd(2'd2, F_SRC_ADDR, 32'h1234_5678, "rdw_new");
    wr(2'd1, F_SRC_SIZE, 32'hFFFF_FFFF);
    rd(2'd1, F_SRC_SIZE, 32'h03FF_FFFF, "trunc");

    for (int i = 0; i < 4; i++) begin
      wr(2'(i), F_SRC_ADDR, 32'hA000_0000 + 32'(i));
      wr(2'(i), F_DES_ADDR, 32'hB000_0000 + 32'(i));
    end

    // Three slots, each acknowledged in its fourth valid cycle
    for (int i = 0; i < 3; i++) push_issue(i, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
    bus.seq_count = 3'd3; bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    check("run_busy", {31'b0, bus.seq_busy}, 32'h1);
    for (int s = 0; s < 3; s++) begin
      tick(3);
      bus.cur_ack = 1'b1;
      if (s == 2) done_q.push_back(cyc + 1);
      tick();
      bus.cur_ack = 1'b0;
    end
    tick(2);
    for (int s = 0; s < 3; s++) begin
      rd(2'(s), F_STATUS, 32'd3, "seq3_status");
      rd(2'(s), F_PROFILE, 32'd4, "seq3_profile");
    end
    rd(2'd3, F_STATUS, 32'd0, "seq3_unused_status");

    // Acknowledge held high: one slot per cycle
    for (int i = 0; i < 4; i++) push_issue(i, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
    done_q.push_back(cyc + 5);
    bus.seq_count = 3'd4; bus.seq_start = 1'b1; bus.cur_ack = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    tick(4);
    bus.cur_ack = 1'b0;
    tick();
    check("held_busy_after", {31'b0, bus.seq_busy}, 32'h0);
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), F_STATUS, 32'd3, "held_status");
      rd(2'(s), F_PROFILE, 32'd1, "held_profile");
    end

    // Illegal counts
    err_q.push_back(cyc + 1);
    bus.seq_count = 3'd0; bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    check("err0_busy", {31'b0, bus.seq_busy}, 32'h0);
    tick();
    err_q.push_back(cyc + 1);
    bus.seq_count = 3'd5; bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    check("err5_busy", {31'b0, bus.seq_busy}, 32'h0);
    tick(2);

    // Abort coinciding with the acknowledge of slot 1
    push_issue(0, 32'hA000_0000, 32'hB000_0000);
    push_issue(1, 32'hA000_0001, 32'hB000_0001);
    bus.seq_count = 3'd3; bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0; bus.cur_ack = 1'b1;
    tick();
    bus.seq_abort = 1'b1;
    tick();
    bus.seq_abort = 1'b0; bus.cur_ack = 1'b0;
    check("abort_busy", {31'b0, bus.seq_busy}, 32'h0);
    check("abort_valid", {31'b0, bus.cur_valid}, 32'h0);
    rd(2'd0, F_STATUS, 32'd3, "abort_s0_status");
    rd(2'd1, F_STATUS, 32'd0, "abort_s1_status");
    tick(2);

    // Host writes during a run: running slot locked, idle slot writable
    push_issue(0, 32'hA000_0000, 32'hB000_0000);
    push_issue(1, 32'hA000_0001, 32'h0000_5678);
    bus.seq_count = 3'd2; bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    wr(2'd0, F_DES_ADDR, 32'h0000_1234);
    wr(2'd1, F_DES_ADDR, 32'h0000_5678);
    done_q.push_back(cyc + 2);
    bus.cur_ack = 1'b1;
    tick(2);
    bus.cur_ack = 1'b0;
    tick(2);
    rd(2'd0, F_DES_ADDR, 32'hB000_0000, "locked_des");
    rd(2'd1, F_DES_ADDR, 32'h0000_5678, "open_des");
    rd(2'd0, F_PROFILE, 32'd3, "lock_s0_profile");
    rd(2'd1, F_PROFILE, 32'd1, "lock_s1_profile");
    tick(3);

    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    check("issue_queue_drained", 32'(iss_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    check("err_queue_drained", 32'(err_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
